// File: rtl/int_adder_arbiter.sv
// Round-robin arbiter sharing one int_carry_adder between NUM_REQ valid/ready requesters.
// The registered tagged response has backpressure. Per-requester grant counters are built only with ADDER_ARB_STATS_EN.

module int_carry_adder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, carry_in};
endmodule

module int_adder_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_sum,
    output logic                          rsp_carry
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt
`endif
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]            state;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   ptr_next;
    logic                  found;
    logic                  out_free;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_carry;

    assign rsp_valid = (state == FULL);
    assign out_free  = !rsp_valid || rsp_ready;
    // Reset gates the grant so no requester sees ready while rst is high.
    assign transfer  = found && out_free && !rst;

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        winner    = ptr;
        found     = 1'b0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_WIDTH'(idx);
            end
        end
        if (transfer) req_ready[winner] = 1'b1;
        ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end

    assign sel_a = req_a[winner*DATA_WIDTH +: DATA_WIDTH];
    assign sel_b = req_b[winner*DATA_WIDTH +: DATA_WIDTH];

    int_carry_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
        .a         (sel_a),
        .b         (sel_b),
        .carry_in  (1'b0),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            ptr       <= '0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
        end else if (transfer) begin
            state     <= FULL;
            ptr       <= ptr_next;
            rsp_id    <= winner;
            rsp_sum   <= add_sum;
            rsp_carry <= add_carry;
        end else if (rsp_ready) begin
            state <= EMPTY;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (transfer && int'(winner) == g && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
        assign grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end
`endif

endmodule
